// File: rtl/upg_pkg.sv
// Shared types and constants for the program-ROM UART word loader.
package upg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LENHI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned UPG_ADR_W       = 14;
    localparam int unsigned UPG_DAT_W       = 32;
    localparam int unsigned UPG_DEPTH_WORDS = 16384;
    localparam int unsigned UPG_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/upg_gap_timer.sv
// Inter-byte gap counter: pulses expire on the TIMEOUT_CYC-th quiet enabled cycle.
module upg_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // A clear in the same cycle masks expiry, so a late byte still wins.
    assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || clr) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/upg_word_loader.sv
// Framed UART download checker and little-endian word assembler feeding the
// program ROM write port.
module upg_word_loader
    import upg_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = UPG_DEPTH_WORDS,
    parameter int unsigned TIMEOUT_CYC = UPG_TIMEOUT_CYC
) (
    input  logic                 upg_clk_i,
    input  logic                 upg_rstn_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 restart_i,
    output logic                 upg_wen_o,
    output logic [UPG_ADR_W-1:0] upg_adr_o,
    output logic [UPG_DAT_W-1:0] upg_dat_o,
    output logic                 upg_done_o,
    output logic                 upg_err_o,
    output logic                 busy_o
);

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [7:0]  xor_acc;
    logic        expire;
    logic [15:0] n_formed;
    logic        last_word;

    assign n_formed  = {rx_data_i, len_lo};
    assign last_word = (word_idx + 16'd1) == word_cnt;

    upg_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk   (upg_clk_i),
        .rst_n (upg_rstn_i),
        .en    (busy_o),
        .clr   (rx_valid_i || restart_i),
        .expire(expire)
    );

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        upg_done_o = (state == DONE);
        upg_err_o  = (state == ERR);
        busy_o     = (state == LENHI) || (state == DATA) || (state == CSUM);
        if (restart_i) begin
            state_nxt = IDLE;
        end else if (rx_valid_i) begin
            case (state)
                IDLE:  state_nxt = LENHI;
                LENHI: begin
                    if (32'(n_formed) > DEPTH_WORDS) state_nxt = ERR;
                    else if (n_formed == 16'd0)      state_nxt = CSUM;
                    else                             state_nxt = DATA;
                end
                DATA:  if (byte_idx == 2'd3 && last_word) state_nxt = CSUM;
                CSUM:  state_nxt = (rx_data_i == xor_acc) ? DONE : ERR;
                default: state_nxt = state;
            endcase
        end else if (expire) begin
            state_nxt = ERR;
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            len_lo    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
            xor_acc   <= '0;
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            upg_wen_o <= 1'b0;
            if (restart_i) begin
                word_idx <= '0;
                byte_idx <= '0;
                asm_q    <= '0;
                xor_acc  <= '0;
            end else if (rx_valid_i) begin
                case (state)
                    IDLE: begin
                        len_lo  <= rx_data_i;
                        xor_acc <= xor_acc ^ rx_data_i;
                    end
                    LENHI: begin
                        word_cnt <= n_formed;
                        xor_acc  <= xor_acc ^ rx_data_i;
                    end
                    DATA: begin
                        xor_acc  <= xor_acc ^ rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            upg_wen_o <= 1'b1;
                            upg_adr_o <= word_idx[UPG_ADR_W-1:0];
                            upg_dat_o <= {rx_data_i, asm_q};
                            word_idx  <= word_idx + 16'd1;
                        end else begin
                            asm_q <= {rx_data_i, asm_q[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upg_word_loader.sv
// Randomized and directed frames checked against a byte-list reference model.
module tb_upg_word_loader;

    localparam int unsigned TMO   = 40;
    localparam int unsigned DEPTH = 16384;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        restart = 1'b0;
    logic        wen;
    logic [13:0] adr;
    logic [31:0] dat;
    logic        done;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [45:0] exp_q[$];

    upg_word_loader #(
        .DEPTH_WORDS(DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .upg_clk_i (clk),
        .upg_rstn_i(rst_n),
        .rx_valid_i(rx_valid),
        .rx_data_i (rx_data),
        .restart_i (restart),
        .upg_wen_o (wen),
        .upg_adr_o (adr),
        .upg_dat_o (dat),
        .upg_done_o(done),
        .upg_err_o (err),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next word the model predicted.
    always @(negedge clk) begin
        if (rst_n && wen) begin
            if (exp_q.size() == 0) begin
                check("wen_unexpected", 64'({adr, dat}), 64'd0);
            end else begin
                check("write", 64'({adr, dat}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Returns 0 = frame incomplete, 1 = done, 2 = error; queues expected writes.
    function automatic int model(input bq_t b);
        int n;
        int base;
        logic [7:0] x;
        if (b.size() < 2) return 0;
        n = int'(b[0]) + 256 * int'(b[1]);
        if (n > int'(DEPTH)) return 2;
        for (int k = 0; k < n; k++) begin
            base = 2 + 4 * k;
            if (base + 3 < b.size())
                exp_q.push_back({14'(k), b[base+3], b[base+2], b[base+1], b[base]});
        end
        if (b.size() <= 2 + 4 * n) return 0;
        x = '0;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ b[i];
        return (b[2+4*n] == x) ? 1 : 2;
    endfunction

    function automatic bq_t make_frame(input int n, input bit corrupt);
        bq_t b;
        logic [7:0] x;
        logic [15:0] n16;
        n16 = 16'(n);
        b.push_back(n16[7:0]);
        b.push_back(n16[15:8]);
        for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
        x = '0;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
        return b;
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("restart_state", 64'({busy, done, err}), 64'd0);
    endtask

    task automatic run_frame(input string tag, input bq_t b, input int gap_max);
        int st;
        st = model(b);
        foreach (b[i]) begin
            send_byte(b[i]);
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
        idle(3);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_status"}, 64'({busy, done, err}),
              64'({st == 0 && b.size() > 0, st == 1, st == 2}));
    endtask

    bq_t fr;
    int  n;

    initial begin
        #1;
        check("reset_outputs", 64'({wen, adr, dat, done, err, busy}), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("post_reset", 64'({wen, adr, dat, done, err, busy}), 64'd0);

        // Reference frame with known content and checksum
        fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        run_frame("t1", fr, 0);
        check("t1_hold", 64'({adr, dat}), 64'({14'd1, 32'h88776655}));
        pulse_restart();

        fr[10] = 8'h8B;
        run_frame("t2", fr, 0);
        pulse_restart();

        fr = '{8'h00, 8'h00, 8'h00};
        run_frame("t3", fr, 0);
        pulse_restart();

        // Oversize length: error right after LEN_HI, later bytes ignored
        send_byte(8'h01);
        send_byte(8'h40);
        check("t4_err_now", 64'({busy, done, err}), 64'b001);
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        foreach (fr[i]) send_byte(fr[i]);
        idle(2);
        check("t4_still_err", 64'({busy, done, err}), 64'b001);
        pulse_restart();

        // Timeout boundary
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        void'(model(fr));
        foreach (fr[i]) send_byte(fr[i]);
        idle(TMO - 1);
        check("t5_gap_minus1", 64'({busy, done, err}), 64'b100);
        idle(1);
        check("t5_timeout", 64'({busy, done, err}), 64'b001);
        pulse_restart();

        fr = make_frame(1, 1'b0);
        void'(model(fr));
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (i < fr.size() - 1) idle(TMO - 1);
        end
        idle(2);
        check("t5_slow_done", 64'({busy, done, err}), 64'b010);
        pulse_restart();

        // Restart wins over a byte in the same cycle
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        fr = '{8'h00, 8'h00, 8'h00};
        run_frame("restart_byte", fr, 0);
        pulse_restart();

        // Asynchronous reset mid-DATA, then a fresh frame from address 0
        fr = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
        void'(model(fr));
        foreach (fr[i]) send_byte(fr[i]);
        idle(2);
        check("t6_busy", 64'(busy), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", 64'({wen, adr, dat, done, err, busy}), 64'd0);
        check("t6_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame("t6_fresh", make_frame(1, 1'b0), 0);
        pulse_restart();

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(5, 0);
            fr = make_frame(n, $urandom_range(3, 0) == 0);
            if ($urandom_range(9, 0) == 0) fr[1] = 8'h41;
            run_frame("rand", fr, 2);
            pulse_restart();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
